binary_frame_writer: RTL



---
 rtl/binary_frame_writer_pkg.sv | 17 +
 rtl/raster_addr_counter.sv | 51 +++++
 rtl/binary_frame_writer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/binary_frame_writer_pkg.sv
// Shared types and constants for the binary frame writer and its median-stage peer.
// Holds FSM encoding, address width and default image dimensions.
package binary_frame_writer_pkg;

  localparam int ADDR_W         = 8;
  localparam int DEF_IMG_WIDTH  = 160;
  localparam int DEF_IMG_HEIGHT = 120;
  localparam int FG_CNT_W       = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_FLUSH,
    ST_HANDOFF
  } bfw_state_e;

endpackage

// File: rtl/raster_addr_counter.sv
// Raster x/y counter: x_o/y_o is the address of the pixel accepted this cycle.
// A clear in the same cycle as an advance makes that pixel (0,0).
module raster_addr_counter
  import binary_frame_writer_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] x_o,
  output logic [ADDR_W-1:0] y_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] XMAX = ADDR_W'(IMG_WIDTH - 1);
  localparam logic [ADDR_W-1:0] YMAX = ADDR_W'(IMG_HEIGHT - 1);

  logic [ADDR_W-1:0] x_q, x_d;
  logic [ADDR_W-1:0] y_q, y_d;

  assign x_o    = clr_i ? '0 : x_q;
  assign y_o    = clr_i ? '0 : y_q;
  assign last_o = (x_o == XMAX) && (y_o == YMAX);

  always_comb begin
    x_d = x_o;
    y_d = y_o;
    if (adv_i) begin
      if (x_o == XMAX) begin
        x_d = '0;
        y_d = (y_o == YMAX) ? '0 : y_o + 1'b1;
      end else begin
        x_d = x_o + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/binary_frame_writer.sv
// Binarises a raster pixel stream into the binary image memory, then hands off.
// Optional FG_PIXEL_COUNT_EN adds a saturating count of 1-pixels per frame.
module binary_frame_writer
  import binary_frame_writer_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int PIX_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frameStart,
  input  logic              pixelValid,
  input  logic [PIX_W-1:0]  pixelIn,
  input  logic [PIX_W-1:0]  grayThreshold,
  input  logic              fullImageDone,
  output logic              binaryWriteEn,
  output logic              binaryDataOut,
  output logic [ADDR_W-1:0] xAddressOut,
  output logic [ADDR_W-1:0] yAddressOut,
  output logic              start,
  output logic              syncError
`ifdef FG_PIXEL_COUNT_EN
  ,
  output logic [FG_CNT_W-1:0] fgPixelCount
`endif
);

  bfw_state_e        state_q;
  logic [PIX_W-1:0]  thr_q;
  logic [PIX_W-1:0]  thr_eff;
  logic              acc_start;
  logic              acc_pix;
  logic              pix_bit;
  logic              last;
  logic [ADDR_W-1:0] cur_x;
  logic [ADDR_W-1:0] cur_y;

  assign acc_start = frameStart &&
                     (state_q == ST_IDLE || state_q == ST_CAPTURE);
  assign acc_pix   = pixelValid &&
                     (state_q == ST_CAPTURE || acc_start);
  // A pixel arriving with frameStart uses the threshold being latched.
  assign thr_eff   = acc_start ? grayThreshold : thr_q;
  assign pix_bit   = pixelIn > thr_eff;

  raster_addr_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (acc_start),
    .adv_i (acc_pix),
    .x_o   (cur_x),
    .y_o   (cur_y),
    .last_o(last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      thr_q         <= '0;
      binaryWriteEn <= 1'b0;
      binaryDataOut <= 1'b0;
      xAddressOut   <= '0;
      yAddressOut   <= '0;
      start         <= 1'b0;
      syncError     <= 1'b0;
    end else begin
      binaryWriteEn <= 1'b0;
      syncError     <= 1'b0;
      if (acc_start) thr_q <= grayThreshold;
      if (acc_pix) begin
        binaryWriteEn <= 1'b1;
        binaryDataOut <= pix_bit;
        xAddressOut   <= cur_x;
        yAddressOut   <= cur_y;
      end
      unique case (state_q)
        ST_IDLE, ST_CAPTURE: begin
          if (state_q == ST_CAPTURE && frameStart)
            syncError <= 1'b1;
          if (acc_pix && last)
            state_q <= ST_FLUSH;
          else if (acc_start)
            state_q <= ST_CAPTURE;
        end
        ST_FLUSH: begin
          state_q <= ST_HANDOFF;
          start   <= 1'b1;
        end
        ST_HANDOFF: begin
          if (frameStart) syncError <= 1'b1;
          if (fullImageDone) begin
            state_q <= ST_IDLE;
            start   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef FG_PIXEL_COUNT_EN
  logic [FG_CNT_W-1:0] fg_q;

  assign fgPixelCount = fg_q;

  always_ff @(posedge clk) begin
    if (!reset)
      fg_q <= '0;
    else if (acc_start)
      fg_q <= (acc_pix && pix_bit) ? FG_CNT_W'(1) : '0;
    else if (acc_pix && pix_bit && fg_q != '1)
      fg_q <= fg_q + 1'b1;
  end
`endif

endmodule
